// File: rtl/sram_mem_responder_pkg.sv
// Shared types and constants for the 32-bit-over-16-bit SRAM responder.
// FSM encoding, SRAM data width and default memory window base.
package sram_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_e;

  localparam int          SRAM_DW       = 16;
  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_mem_responder_wait_counter.sv
// Loadable down-counter with zero flag; sets the hold time of each
// half-word SRAM access.
module sram_wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sram_mem_responder.sv
// MEM-stage word responder over a 16-bit async SRAM, low half first.
// Optional SRAM_LAST_READ_BYPASS_EN: last-word register serves repeat reads.
module sram_mem_responder
  import sram_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          WAIT_CYCLES = 5,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n
);

  localparam int IW = SRAM_AW - 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e state_q, state_d;

  logic               op_wr_q, op_wr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [SRAM_DW-1:0] dq_out_q, dq_out_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;

  logic          req;
  logic [IW-1:0] idx_in;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_zero;
  logic          hit;
  logic [31:0]   byp_data;

  assign req    = rd_en | wr_en;
  assign idx_in = IW'((address - BASE_ADDR) >> 2);

  sram_wait_counter #(
    .W (CW)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CW'(WAIT_CYCLES - 1)),
    .zero     (cnt_zero)
  );

`ifdef SRAM_LAST_READ_BYPASS_EN
  logic          byp_valid_q, byp_valid_d;
  logic [IW-1:0] byp_idx_q, byp_idx_d;
  logic [31:0]   byp_data_q, byp_data_d;

  assign hit = (state_q == ST_IDLE) & rd_en & ~wr_en
             & byp_valid_q & (byp_idx_q == idx_in);
  assign byp_data = byp_data_q;

  always_comb begin
    byp_valid_d = byp_valid_q;
    byp_idx_d   = byp_idx_q;
    byp_data_d  = byp_data_q;
    if (state_q == ST_DONE) begin
      byp_valid_d = 1'b1;
      byp_idx_d   = idx_q;
      byp_data_d  = op_wr_q ? wdata_q : rdata_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_valid_q <= 1'b0;
      byp_idx_q   <= '0;
      byp_data_q  <= '0;
    end else begin
      byp_valid_q <= byp_valid_d;
      byp_idx_q   <= byp_idx_d;
      byp_data_q  <= byp_data_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign byp_data = '0;
`endif

  always_comb begin
    state_d  = state_q;
    op_wr_d  = op_wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    oe_d     = oe_q;
    we_n_d   = we_n_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          rdata_d = byp_data;
        end else if (req) begin
          op_wr_d  = wr_en;
          idx_d    = idx_in;
          wdata_d  = write_data;
          cnt_load = 1'b1;
          addr_d   = {idx_in, 1'b0};
          dq_out_d = write_data[15:0];
          oe_d     = wr_en;
          we_n_d   = ~wr_en;
          state_d  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_zero) begin
          if (!op_wr_q) rdata_d[15:0] = sram_dq_in;
          // Strobe released across the half switch so the address settles
          cnt_load = 1'b1;
          addr_d   = {idx_q, 1'b1};
          dq_out_d = wdata_q[31:16];
          we_n_d   = 1'b1;
          state_d  = ST_HIGH;
        end else begin
          cnt_dec = 1'b1;
          we_n_d  = ~op_wr_q;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          if (!op_wr_q) rdata_d[31:16] = sram_dq_in;
          oe_d    = 1'b0;
          we_n_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
          we_n_d  = ~op_wr_q;
        end
      end
      ST_DONE: begin
        oe_d    = 1'b0;
        we_n_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_wr_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      oe_q     <= 1'b0;
      we_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_wr_q  <= op_wr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      oe_q     <= oe_d;
      we_n_q   <= we_n_d;
    end
  end

  assign ready = (state_q == ST_DONE)
               | ((state_q == ST_IDLE) & ~req)
               | hit;

  assign read_data   = hit ? byp_data : rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

endmodule
